// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write-back, read and issue signals of the scoreboarded register file
interface regfile_sb_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int NRD    = 2
);
    logic                   RegWEn;
    logic [AWIDTH-1:0]      AddrD;
    logic [DWIDTH-1:0]      DataD;
    logic [NRD*AWIDTH-1:0]  AddrR;
    logic [NRD*DWIDTH-1:0]  DataR;
    logic                   IssueEn;
    logic [AWIDTH-1:0]      AddrI;
    logic [NRD-1:0]         BusyR;
    logic                   BusyAny;
    modport master (output RegWEn, AddrD, DataD, AddrR, IssueEn, AddrI, input DataR, BusyR, BusyAny);
    modport slave  (input RegWEn, AddrD, DataD, AddrR, IssueEn, AddrI, output DataR, BusyR, BusyAny);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with x0 hard-wired, optional bypass/registered reads and a pending-write scoreboard
module regfile_sb #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int RDREG  = 0
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus_io
);
    localparam int DEPTH = 2**AWIDTH;

    logic [DWIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [NRD*DWIDTH-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;

    // write-back clears first and issue sets afterwards, so a newer producer keeps the bit set
    always_comb begin
        busy_d = busy_q;
        if (bus_io.RegWEn) busy_d[bus_io.AddrD] = 1'b0;
        if (bus_io.IssueEn) busy_d[bus_io.AddrI] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // storage update; x0 is never written so it stays zero from reset
    always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        else if (bus_io.RegWEn && bus_io.AddrD != '0) mem_q[bus_io.AddrD] <= bus_io.DataD;
    end

    // scoreboard state
    always_ff @(posedge clk) begin
        busy_q <= rst ? '0 : busy_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AWIDTH-1:0] a;
        logic              hit, iss;
        assign a   = bus_io.AddrR[k*AWIDTH +: AWIDTH];
        assign hit = BYPASS != 0 && bus_io.RegWEn && bus_io.AddrD == a;
        assign iss = bus_io.IssueEn && bus_io.AddrI == a;
        assign rd_data[k*DWIDTH +: DWIDTH] = a == '0 ? '0 : hit ? bus_io.DataD : mem_q[a];
        assign rd_busy[k] = a != '0 && !(hit && !iss) && busy_q[a];
    end

    if (RDREG != 0) begin : g_reg
        logic [NRD*DWIDTH-1:0] data_q;
        logic [NRD-1:0]        rbusy_q;
        // registered read: captures the write-first lookup for use one cycle later
        always_ff @(posedge clk) begin
            data_q  <= rst ? '0 : rd_data;
            rbusy_q <= rst ? '0 : rd_busy;
        end
        assign bus_io.DataR = data_q;
        assign bus_io.BusyR = rbusy_q;
    end else begin : g_comb
        assign bus_io.DataR = rd_data;
        assign bus_io.BusyR = rd_busy;
    end

    assign bus_io.BusyAny = |busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb in three bypass/read-mode configurations
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst, we, ie;
    logic [4:0]  ad, ai;
    logic [31:0] dd;
    logic [4:0]  ar [2];
    int n_chk = 0, n_fail = 0;

    logic [31:0] mem [32];
    logic [31:0] busy;
    logic [31:0] rexp_d [2];
    logic        rexp_b [2];

    always #5 clk = ~clk;

    regfile_sb_if #(.DWIDTH(32), .AWIDTH(5), .NRD(2)) if0 ();
    regfile_sb_if #(.DWIDTH(32), .AWIDTH(5), .NRD(2)) if1 ();
    regfile_sb_if #(.DWIDTH(32), .AWIDTH(5), .NRD(2)) if2 ();

    assign if0.RegWEn = we; assign if0.AddrD = ad; assign if0.DataD = dd;
    assign if0.AddrR = {ar[1], ar[0]}; assign if0.IssueEn = ie; assign if0.AddrI = ai;
    assign if1.RegWEn = we; assign if1.AddrD = ad; assign if1.DataD = dd;
    assign if1.AddrR = {ar[1], ar[0]}; assign if1.IssueEn = ie; assign if1.AddrI = ai;
    assign if2.RegWEn = we; assign if2.AddrD = ad; assign if2.DataD = dd;
    assign if2.AddrR = {ar[1], ar[0]}; assign if2.IssueEn = ie; assign if2.AddrI = ai;

    regfile_sb #(.DWIDTH(32), .AWIDTH(5), .NRD(2), .BYPASS(1), .RDREG(0)) u0 (.clk(clk), .rst(rst), .bus_io(if0.slave));
    regfile_sb #(.DWIDTH(32), .AWIDTH(5), .NRD(2), .BYPASS(0), .RDREG(0)) u1 (.clk(clk), .rst(rst), .bus_io(if1.slave));
    regfile_sb #(.DWIDTH(32), .AWIDTH(5), .NRD(2), .BYPASS(1), .RDREG(1)) u2 (.clk(clk), .rst(rst), .bus_io(if2.slave));

    function automatic logic [31:0] cexp_d(bit byp, logic [4:0] a);
        return a == 0 ? 32'h0 : (byp && we && ad == a) ? dd : mem[a];
    endfunction

    function automatic logic cexp_b(bit byp, logic [4:0] a);
        return a != 0 && busy[a] && !(byp && we && ad == a && !(ie && ai == a));
    endfunction

    task automatic idle();
        rst = 1'b0; we = 1'b0; ie = 1'b0; ad = '0; ai = '0; dd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) rexp_b[k] = rst ? 1'b0 : cexp_b(1'b1, ar[k]);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = '0;
            busy = '0;
        end else begin
            if (we && ad != 0) mem[ad] = dd;
            if (we) busy[ad] = 1'b0;
            if (ie && ai != 0) busy[ai] = 1'b1;
        end
        for (int k = 0; k < 2; k++) rexp_d[k] = mem[ar[k]];
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle(); we = 1'b1; ad = 5'd5; dd = 32'hDEADBEEF; ie = 1'b1; ai = 5'd5;
        tick();
        idle(); ar[0] = 5'd5; ar[1] = 5'd5; rst = 1'b1; we = 1'b1; ad = 5'd5; dd = 32'h1; ie = 1'b1; ai = 5'd6;
        tick();
        idle(); #1;
        n_chk++; if (if0.DataR[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", if0.DataR[31:0]); end
        n_chk++; if (if0.BusyR !== 2'b00) begin n_fail++; $display("FAIL reset_busyr got %b exp 00", if0.BusyR); end
        n_chk++; if (if0.BusyAny !== 1'b0) begin n_fail++; $display("FAIL reset_busyany got %b exp 0", if0.BusyAny); end
        n_chk++; if (if2.DataR !== 64'h0 || if2.BusyR !== 2'b00) begin n_fail++; $display("FAIL reset_regread got %h/%b exp 0/00", if2.DataR, if2.BusyR); end
    endtask

    task automatic test_x0();
        idle(); we = 1'b1; ad = 5'd0; dd = 32'hFFFFFFFF; ie = 1'b1; ai = 5'd0; ar[0] = 5'd0; #1;
        n_chk++; if (if0.DataR[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got %h exp 0", if0.DataR[31:0]); end
        tick();
        idle(); #1;
        n_chk++; if (if0.DataR[31:0] !== 32'h0 || if1.DataR[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_read got %h/%h exp 0", if0.DataR[31:0], if1.DataR[31:0]); end
        n_chk++; if (if0.BusyAny !== 1'b0 || if0.BusyR[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b/%b exp 0/0", if0.BusyAny, if0.BusyR[0]); end
    endtask

    task automatic test_bypass();
        idle(); we = 1'b1; ad = 5'd7; dd = 32'h11;
        tick();
        we = 1'b1; ad = 5'd7; dd = 32'h22; ar[0] = 5'd7; #1;
        n_chk++; if (if0.DataR[31:0] !== 32'h22) begin n_fail++; $display("FAIL bypass_on got %h exp 22", if0.DataR[31:0]); end
        n_chk++; if (if1.DataR[31:0] !== 32'h11) begin n_fail++; $display("FAIL bypass_off got %h exp 11", if1.DataR[31:0]); end
        tick();
        idle(); #1;
        n_chk++; if (if1.DataR[31:0] !== 32'h22) begin n_fail++; $display("FAIL bypass_off_next got %h exp 22", if1.DataR[31:0]); end
    endtask

    task automatic test_regread();
        idle(); we = 1'b1; ad = 5'd3; dd = 32'h1234; ar[1] = 5'd0;
        tick();
        idle(); ar[1] = 5'd3; #1;
        n_chk++; if (if2.DataR[63:32] !== 32'h0) begin n_fail++; $display("FAIL regread_early got %h exp 0", if2.DataR[63:32]); end
        tick(); #1;
        n_chk++; if (if2.DataR[63:32] !== 32'h1234) begin n_fail++; $display("FAIL regread_late got %h exp 1234", if2.DataR[63:32]); end
        we = 1'b1; ad = 5'd3; dd = 32'h5678;
        tick();
        idle(); #1;
        n_chk++; if (if2.DataR[63:32] !== 32'h5678) begin n_fail++; $display("FAIL regread_wfirst got %h exp 5678", if2.DataR[63:32]); end
    endtask

    task automatic test_scoreboard();
        idle(); ie = 1'b1; ai = 5'd9; ar[0] = 5'd9;
        tick();
        idle(); #1;
        n_chk++; if (if0.BusyR[0] !== 1'b1 || if0.BusyAny !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b/%b exp 1/1", if0.BusyR[0], if0.BusyAny); end
        we = 1'b1; ad = 5'd9; dd = 32'h99; #1;
        n_chk++; if (if0.BusyR[0] !== 1'b0) begin n_fail++; $display("FAIL sb_mask got %b exp 0", if0.BusyR[0]); end
        n_chk++; if (if1.BusyR[0] !== 1'b1 || if0.BusyAny !== 1'b1) begin n_fail++; $display("FAIL sb_nomask got %b/%b exp 1/1", if1.BusyR[0], if0.BusyAny); end
        tick();
        idle(); #1;
        n_chk++; if (if0.BusyAny !== 1'b0 || if1.BusyR[0] !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b/%b exp 0/0", if0.BusyAny, if1.BusyR[0]); end
        ie = 1'b1; ai = 5'd9;
        tick();
        we = 1'b1; ad = 5'd9; dd = 32'hABCD; ie = 1'b1; ai = 5'd9;
        tick();
        idle(); #1;
        n_chk++; if (if0.BusyR[0] !== 1'b1 || if0.BusyAny !== 1'b1) begin n_fail++; $display("FAIL sb_setwins got %b/%b exp 1/1", if0.BusyR[0], if0.BusyAny); end
        n_chk++; if (if0.DataR[31:0] !== 32'hABCD) begin n_fail++; $display("FAIL sb_setwins_data got %h exp abcd", if0.DataR[31:0]); end
        we = 1'b1; ad = 5'd9; dd = 32'h5;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = $urandom_range(0, 49) == 0;
            we = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 2) == 0);
            ad = 5'($urandom_range(0, 15)); ai = 5'($urandom_range(0, 15));
            dd = $urandom;
            ar[0] = 5'($urandom_range(0, 15));
            ar[1] = $urandom_range(0, 3) == 0 ? ar[0] : 5'($urandom_range(0, 15));
            #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (if0.DataR[k*32 +: 32] !== cexp_d(1'b1, ar[k])) begin n_fail++; $display("FAIL rnd_byp_data[%0d] cyc %0d got %h exp %h", k, n, if0.DataR[k*32 +: 32], cexp_d(1'b1, ar[k])); end
                n_chk++; if (if0.BusyR[k] !== cexp_b(1'b1, ar[k])) begin n_fail++; $display("FAIL rnd_byp_busy[%0d] cyc %0d got %b exp %b", k, n, if0.BusyR[k], cexp_b(1'b1, ar[k])); end
                n_chk++; if (if1.DataR[k*32 +: 32] !== cexp_d(1'b0, ar[k])) begin n_fail++; $display("FAIL rnd_nobyp_data[%0d] cyc %0d got %h exp %h", k, n, if1.DataR[k*32 +: 32], cexp_d(1'b0, ar[k])); end
                n_chk++; if (if1.BusyR[k] !== cexp_b(1'b0, ar[k])) begin n_fail++; $display("FAIL rnd_nobyp_busy[%0d] cyc %0d got %b exp %b", k, n, if1.BusyR[k], cexp_b(1'b0, ar[k])); end
                n_chk++; if (if2.DataR[k*32 +: 32] !== rexp_d[k]) begin n_fail++; $display("FAIL rnd_reg_data[%0d] cyc %0d got %h exp %h", k, n, if2.DataR[k*32 +: 32], rexp_d[k]); end
                n_chk++; if (if2.BusyR[k] !== rexp_b[k]) begin n_fail++; $display("FAIL rnd_reg_busy[%0d] cyc %0d got %b exp %b", k, n, if2.BusyR[k], rexp_b[k]); end
            end
            n_chk++; if (if0.BusyAny !== (|busy) || if1.BusyAny !== (|busy) || if2.BusyAny !== (|busy)) begin n_fail++; $display("FAIL rnd_busyany cyc %0d got %b%b%b exp %b", n, if0.BusyAny, if1.BusyAny, if2.BusyAny, |busy); end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        busy = '0;
        rexp_d[0] = '0; rexp_d[1] = '0; rexp_b[0] = 1'b0; rexp_b[1] = 1'b0;
        idle(); ar[0] = '0; ar[1] = '0;
        rst = 1'b1;
        tick(); tick();
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_regread();
        test_scoreboard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core integer register file for the rv32i pipeline. Provides NRD read ports and one write-back port. Register 0 is hard-wired to zero. Same-cycle write-to-read bypass and registered-read mode are selectable. A per-register pending-write scoreboard lets decode detect RAW hazards without a separate hazard table.

Parameters:
- DWIDTH, 32, data width of each register.
- AWIDTH, 5, address width; depth is 2**AWIDTH.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write-back data is forwarded to matching read ports; 0 = reads return the stored value.
- RDREG, 0, 0 = combinational reads; 1 = registered reads with 1-cycle latency.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- RegWEn  in  1  write-back enable.
- AddrD  in  AWIDTH  write-back address.
- DataD  in  DWIDTH  write-back data.
- AddrR  in  NRD*AWIDTH  packed read addresses; port k uses bits [k*AWIDTH +: AWIDTH].
- DataR  out  NRD*DWIDTH  packed read data; port k uses bits [k*DWIDTH +: DWIDTH].
- IssueEn  in  1  marks destination AddrI as pending (instruction issued).
- AddrI  in  AWIDTH  issued destination address.
- BusyR  out  NRD  per-read-port pending flag for AddrR[k].
- BusyAny  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (rst=1 at posedge):
  - all 2**AWIDTH registers cleared to 0;
  - all scoreboard bits cleared;
  - in RDREG=1 mode, DataR and BusyR registers cleared to 0.
  - Reset wins over any simultaneous RegWEn or IssueEn.
  - After reset, DataR reads 0 for every address, and BusyR and BusyAny are 0.
- Write: at posedge with RegWEn=1 and AddrD!=0, mem[AddrD] <= DataD. Writes to address 0 are ignored.
- Register 0 always reads 0, is never busy, and IssueEn with AddrI=0 is ignored.
- Read, RDREG=0 (combinational, 0 latency): DataR[k] = 0 if AddrR[k]==0.
  - Otherwise, if BYPASS=1 and RegWEn and AddrD==AddrR[k], DataR[k] = DataD.
  - Otherwise DataR[k] = mem[AddrR[k]].
- Read, RDREG=1 (1-cycle latency): DataR[k] is registered at posedge from AddrR[k] and is write-first.
  - A same-edge write to the same address yields the new DataD if BYPASS=1, or the old value if BYPASS=0.
- Multiple read ports on the same address return identical data in the same cycle.
- Scoreboard: busy[i] is set at posedge when IssueEn=1 and AddrI==i (i!=0).
  - busy[i] is cleared at posedge when RegWEn=1 and AddrD==i.
  - Simultaneous issue and write-back to the same address: set wins, because the newer producer is outstanding.
  - Issue to an already-busy register: it stays busy (WAW allowed).
  - Write-back to a non-busy register: the data is written and the bit stays 0.
- BusyR[k] timing follows RDREG: combinational in RDREG=0 mode, registered alongside DataR in RDREG=1 mode.
  - If BYPASS=1, a same-cycle write-back to AddrR[k] masks BusyR[k] to 0, unless IssueEn targets the same address in that cycle.
- BusyAny = |busy, registered state only, 0 latency.
- Width rules: DataD is stored exactly with no extension. Out-of-range addresses are impossible because depth = 2**AWIDTH.

Test Plan:
- Reset: write 0xDEADBEEF to x5, then assert rst one cycle -> x5 reads 0x00000000; BusyR=0; BusyAny=0.
- x0 protection: RegWEn=1, AddrD=0, DataD=0xFFFFFFFF; IssueEn with AddrI=0 -> AddrR=0 reads 0; BusyAny stays 0.
- Bypass, BYPASS=1, RDREG=0: x7=0x11, then same cycle RegWEn, AddrD=7, DataD=0x22, AddrR port0=7 -> DataR port0=0x22 combinationally. With BYPASS=0 -> 0x11 that cycle, 0x22 next cycle.
- Registered read, RDREG=1: AddrR port1=3 with x3=0x1234 -> DataR port1=0x1234 one cycle later, not before. Same-edge write of 0x5678 to x3 with BYPASS=1 -> 0x5678.
- Scoreboard, part 1: IssueEn with AddrI=9 -> next cycle, reading 9 gives BusyR=1 and BusyAny=1. Then RegWEn with AddrD=9 -> BusyR=0 in that cycle (BYPASS=1) and the bit clears at the edge.
- Scoreboard, part 2: simultaneous IssueEn with AddrI=9 and RegWEn with AddrD=9 -> busy[9] remains 1 and x9 is updated.
